// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART deframer (start, 8 data LSB first,
// parity, stop) with parity/framing flags and an optional idle-timeout.
// Build option: define UART_RX_TIMEOUT_EN to include the idle-timeout monitor.
// Ports: clk, reset (async, active-low), rx_en, rx_d (async serial in);
//        rx_data[7:0], rx_valid, rx_perror, rx_ferror, rx_busy, rx_timeout.
module uart_receiver #(
    parameter int unsigned CLKS_PER_TICK  = 326,
    parameter bit          PARITY_ODD     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx_d,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_perror,
    output logic       rx_ferror,
    output logic       rx_busy,
    output logic       rx_timeout
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_TICK - 1);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= 2 ** 26) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2 .. 2**26-1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, rxs_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    vote_q, vote_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_perror_q, rx_perror_d;
    logic          rx_ferror_q, rx_ferror_d;

    logic tick;
    logic bit_end;
    logic maj_bit;
    logic maj_stop;
    logic start_det;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign tick      = (state_q != S_IDLE) && (tick_cnt_q == TICK_MAX);
    assign bit_end   = tick && (samp_cnt_q == 4'd15);
    assign maj_bit   = maj3(vote_q[0], vote_q[1], vote_q[2]);
    // Stop is decided on the tick-9 sample itself, before it is registered.
    assign maj_stop  = maj3(vote_q[0], vote_q[1], rxs_q);
    assign start_det = (state_q == S_IDLE) && rx_en && !rxs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_d;
            rxs_q   <= sync1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d  = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        vote_d      = vote_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_perror_d = rx_perror_q;
        rx_ferror_d = rx_ferror_q;

        if (tick && samp_cnt_q == 4'd7) vote_d[0] = rxs_q;
        if (tick && samp_cnt_q == 4'd8) vote_d[1] = rxs_q;
        if (tick && samp_cnt_q == 4'd9) vote_d[2] = rxs_q;

        unique case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                if (start_det) state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = maj_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {maj_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_err_d = ^{shift_q, maj_bit} ^ PARITY_ODD;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Leave one clk after the strobe so busy drops after valid.
                if (rx_valid_q) begin
                    state_d = S_IDLE;
                end else if (tick && samp_cnt_q == 4'd9) begin
                    rx_valid_d  = 1'b1;
                    rx_data_d   = shift_q;
                    rx_perror_d = par_err_q;
                    rx_ferror_d = ~maj_stop;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            vote_q      <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perror_q <= 1'b0;
            rx_ferror_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            vote_q      <= vote_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_perror_q <= rx_perror_d;
            rx_ferror_q <= rx_ferror_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_perror = rx_perror_q;
    assign rx_ferror = rx_ferror_q;
    assign rx_busy   = (state_q != S_IDLE);

`ifdef UART_RX_TIMEOUT_EN
    // Registered pulse: firing one count early lands it exactly
    // TIMEOUT_CYCLES clocks after the rx_valid cycle.
    localparam logic [25:0] TO_FIRE = 26'(TIMEOUT_CYCLES - 2);

    logic [25:0] idle_cnt_q, idle_cnt_d;
    logic        armed_q, armed_d;
    logic        rx_timeout_q, rx_timeout_d;

    always_comb begin
        idle_cnt_d   = idle_cnt_q;
        armed_d      = armed_q;
        rx_timeout_d = 1'b0;
        if (rx_valid_q) begin
            idle_cnt_d = '0;
            armed_d    = 1'b1;
        end else if (start_det) begin
            idle_cnt_d = '0;
        end else if (armed_q && state_q == S_IDLE) begin
            if (idle_cnt_q == TO_FIRE) begin
                rx_timeout_d = 1'b1;
                armed_d      = 1'b0;
                idle_cnt_d   = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 26'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q   <= '0;
            armed_q      <= 1'b0;
            rx_timeout_q <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            armed_q      <= armed_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    assign rx_timeout = rx_timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver (even and odd parity
// instances), scoreboard of expected bytes/flags, idle-timeout checks.
module tb_uart_receiver;

    localparam int CPT  = 4;
    localparam int TO   = 1000;
    localparam int BITC = 16 * CPT;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_en = 1'b0;
    logic       rx_d = 1'b1;
    logic [7:0] rx_data, o_data;
    logic       rx_valid, rx_perror, rx_ferror, rx_busy, rx_timeout;
    logic       o_valid, o_perror, o_ferror, o_busy, o_timeout;

    uart_receiver #(
        .CLKS_PER_TICK(CPT), .PARITY_ODD(1'b0), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rx_d(rx_d),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_perror(rx_perror),
        .rx_ferror(rx_ferror), .rx_busy(rx_busy), .rx_timeout(rx_timeout)
    );

    uart_receiver #(
        .CLKS_PER_TICK(CPT), .PARITY_ODD(1'b1), .TIMEOUT_CYCLES(TO)
    ) dut_odd (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rx_d(rx_d),
        .rx_data(o_data), .rx_valid(o_valid), .rx_perror(o_perror),
        .rx_ferror(o_ferror), .rx_busy(o_busy), .rx_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   fails = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   to_cnt = 0;
    int   to_delta = -1;
    int   last_valid_cyc = 0;
    int   start_cyc = 0;
    int   lat = -1;
    int   vc_before = 0;
    bit   lat_arm = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p,
                                input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp,
                        input int nbits = 11, input int extra = 0);
        logic [10:0] fr;
        fr = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_d = fr[i];
            repeat (BITC) @(posedge clk);
            #1;
        end
        if (extra > 0) begin
            rx_d = fr[nbits];
            repeat (extra) @(posedge clk);
            #1;
        end
        rx_d = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, 32'(rx_data), 0);
        check({tag, "_valid"}, 32'(rx_valid), 0);
        check({tag, "_perror"}, 32'(rx_perror), 0);
        check({tag, "_ferror"}, 32'(rx_ferror), 0);
        check({tag, "_busy"}, 32'(rx_busy), 0);
        check({tag, "_timeout"}, 32'(rx_timeout), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (prev_valid) check("valid_width", 32'(rx_valid), 0);
            if (rx_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                check("valid_vs_timeout", 32'(rx_timeout), 0);
                if (lat_arm) begin
                    lat = cyc - start_cyc;
                    lat_arm = 1'b0;
                end
                check("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(mon_e.data));
                    check("rx_perror", 32'(rx_perror), 32'(mon_e.perr));
                    check("rx_ferror", 32'(rx_ferror), 32'(mon_e.ferr));
                end
            end
            if (rx_timeout) begin
                to_cnt++;
                to_delta = cyc - last_valid_cyc;
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        idle(3);
        check_zero_outputs("reset");
        reset = 1'b1;
        rx_en = 1'b1;
        idle(5);

        start_cyc = cyc;
        lat_arm = 1'b1;
        expect_frame(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b1);
        idle(100);
        check("latency_window", 32'(lat >= 680 && lat <= 688), 1);

        expect_frame(8'h01, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b1);
        idle(100);
        check("odd_perror", 32'(o_perror), 0);
        check("odd_data", 32'(o_data), 32'h01);

        expect_frame(8'h3C, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b0);
        idle(120);
        check("ferr_hold", 32'(rx_ferror), 1);

        expect_frame(8'h55, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1);
        idle(100);
        check("ferr_clear", 32'(rx_ferror), 0);

        vc_before = valid_cnt;
        rx_d = 1'b0;
        idle(16);
        rx_d = 1'b1;
        check("glitch_busy", 32'(rx_busy), 1);
        idle(70);
        check("glitch_idle", 32'(rx_busy), 0);
        check("glitch_data", 32'(rx_data), 32'h55);
        check("glitch_perror", 32'(rx_perror), 0);
        check("glitch_ferror", 32'(rx_ferror), 0);
        check("glitch_novalid", 32'(valid_cnt), 32'(vc_before));

        expect_frame(8'h0F, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b1);
        idle(100);

        send(8'hC3, 1'b0, 1'b1, 4, 32);
        check("mid_busy", 32'(rx_busy), 1);
        reset = 1'b0;
        #1;
        check_zero_outputs("midreset");
        idle(4);
        rx_d = 1'b1;
        reset = 1'b1;
        idle(20);
        check("sb_after_reset", 32'(sb.size()), 0);

        expect_frame(8'h7E, 1'b0, 1'b0);
        send(8'h7E, 1'b0, 1'b1);
        idle(100);

        check("no_early_timeout", 32'(to_cnt), 0);
        expect_frame(8'h11, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b1);
        idle(1200);
        check("timeout_count", 32'(to_cnt), TO_EN ? 1 : 0);
        check("timeout_delay", 32'(to_delta), TO_EN ? TO : -1);

        to_cnt = 0;
        to_delta = -1;
        expect_frame(8'h22, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        while (cyc < last_valid_cyc + 500) @(posedge clk);
        #1;
        expect_frame(8'h33, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b1);
        idle(600);
        check("timeout_suppressed", 32'(to_cnt), 0);
        idle(1000);
        check("timeout2_count", 32'(to_cnt), TO_EN ? 1 : 0);
        check("timeout2_delay", 32'(to_delta), TO_EN ? TO : -1);

        check("sb_empty", 32'(sb.size()), 0);
        check("valid_total", 32'(valid_cnt), 9);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
